// File: rtl/xor_stream_decrypt.sv
// xor_stream_decrypt
//   Byte-serial XOR stream decryptor. Each ciphertext byte is XORed with an
//   LFSR keystream seeded from the loaded key. The keystream restarts from the
//   key after every frame's last byte, so frames decrypt independently. One
//   output register sits between the input and output handshakes.
//
// Ports
//   clk, rst             clock (rising edge), async active-high reset
//   key_load, key_in     1-cycle strobe to latch a key and (re)enter RUN
//   in_valid/in_ready    ciphertext handshake; in_data, in_last
//   out_valid/out_ready  plaintext handshake; out_data, out_last
//   keyed                1 once a key has been loaded
//   byte_count           plaintext bytes delivered since the last key_load
module xor_stream_decrypt #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'hA5,
  parameter int               CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             keyed,
  output logic [CNT_W-1:0] byte_count
);

  typedef enum logic {UNKEYED, RUN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   key_q, key_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   odata_q, odata_d;
  logic               olast_q, olast_d;
  logic               ovld_q, ovld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               in_xfer, out_xfer;
  logic [WIDTH-1:0]   seed, lfsr_step;

  // An all-zero key would lock the LFSR at zero, so substitute the default.
  assign seed      = (key_in == '0) ? DEFAULT_SEED : key_in;
  assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

  assign keyed     = (state_q == RUN);
  // key_load blocks input so a rekey never races a byte using the old key.
  assign in_ready  = keyed && !key_load && (!ovld_q || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = ovld_q && out_ready;

  assign out_valid  = ovld_q;
  assign out_data   = odata_q;
  assign out_last   = olast_q;
  assign byte_count = cnt_q;

  // Next state: only key_load moves the FSM, and it always lands in RUN.
  always_comb begin
    state_d = state_q;
    if (key_load) state_d = RUN;
  end

  // Datapath next-state; key_load is applied last so it overrides the rest.
  always_comb begin
    key_d   = key_q;
    lfsr_d  = lfsr_q;
    odata_d = odata_q;
    olast_d = olast_q;
    ovld_d  = ovld_q;
    cnt_d   = cnt_q;
    if (out_xfer) begin
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      ovld_d = 1'b0;
    end
    if (in_xfer) begin
      odata_d = in_data ^ lfsr_q;
      olast_d = in_last;
      ovld_d  = 1'b1;
      lfsr_d  = in_last ? key_q : lfsr_step;
    end
    if (key_load) begin
      key_d  = seed;
      lfsr_d = seed;
      cnt_d  = '0;
      ovld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNKEYED;
      key_q   <= DEFAULT_SEED;
      lfsr_q  <= DEFAULT_SEED;
      odata_q <= '0;
      olast_q <= 1'b0;
      ovld_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      lfsr_q  <= lfsr_d;
      odata_q <= odata_d;
      olast_q <= olast_d;
      ovld_q  <= ovld_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_xor_stream_decrypt.sv
// Testbench for xor_stream_decrypt: directed scenarios plus a randomized
// round trip through an encryptor model. A cycle-level reference model
// (keystream computed from the key and frame byte index) is checked every cycle.
module tb_xor_stream_decrypt;
  localparam int CNT_W = 8;  // narrow counter so the wrap is reached

  logic             clk = 1'b0;
  logic             rst;
  logic             key_load;
  logic [7:0]       key_in;
  logic             in_valid, in_ready, in_last;
  logic [7:0]       in_data;
  logic             out_valid, out_ready, out_last, keyed;
  logic [7:0]       out_data;
  logic [CNT_W-1:0] byte_count;

  xor_stream_decrypt #(.WIDTH(8), .TAPS(8'hB8), .DEFAULT_SEED(8'hA5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .keyed(keyed), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Keystream byte n of a frame: key stepped n times through the LFSR rule.
  function automatic logic [7:0] ks(input logic [7:0] k, input int n);
    logic [7:0] x;
    x = k;
    for (int i = 0; i < n; i++)
      x = {x[6:0], 1'b0} | 8'($countones(x & 8'hB8) % 2);
    return x;
  endfunction

  // Reference model state
  bit               mkeyed, mov, mlast;
  logic [7:0]       mkey, mdata;
  int               midx;
  logic [CNT_W-1:0] mcnt;

  task automatic model_reset();
    mkeyed = 0; mov = 0; mlast = 0; mkey = 8'hA5; mdata = 8'h00; midx = 0; mcnt = '0;
  endtask

  task automatic drive(input bit kl, input logic [7:0] k, input bit iv,
                       input logic [7:0] d, input bit l, input bit ordy);
    key_load = kl; key_in = k; in_valid = iv; in_data = d; in_last = l; out_ready = ordy;
  endtask

  // One clock: check DUT against the model mid-cycle, advance the model, step the clock.
  task automatic tick();
    bit exp_rdy, ox, ix;
    @(negedge clk);
    exp_rdy = mkeyed && !key_load && (!mov || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, mov);
    chk("keyed", keyed, mkeyed);
    chk("byte_count", byte_count, mcnt);
    if (mov) begin
      chk("out_data", out_data, mdata);
      chk("out_last", out_last, mlast);
    end
    ox = mov && out_ready;
    ix = in_valid && exp_rdy;
    if (key_load) begin
      mkeyed = 1; mkey = (key_in == 8'h00) ? 8'hA5 : key_in; midx = 0; mcnt = '0; mov = 0;
    end else begin
      if (ox) mcnt++;
      if (ix) begin
        mdata = in_data ^ ks(mkey, midx);
        mlast = in_last;
        mov   = 1;
        midx  = in_last ? 0 : midx + 1;
      end else if (ox) mov = 0;
    end
    @(posedge clk); #1;
  endtask

  logic [7:0] c3 [5] = '{8'h41, 8'h42, 8'h44, 8'h48, 8'h11};
  logic [7:0] p3 [5] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h00};

  initial begin
    int acc, cyc;
    bit acc_now;
    logic [7:0] p;

    // Power-on reset
    rst = 1; drive(0, 0, 0, 0, 0, 0); model_reset();
    #12;
    chk("rst_out_valid", out_valid, 0); chk("rst_in_ready", in_ready, 0);
    chk("rst_keyed", keyed, 0); chk("rst_cnt", byte_count, 0); chk("rst_data", out_data, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Unkeyed: input ignored
    drive(0, 0, 1, 8'h55, 0, 1);
    repeat (10) tick();

    // Stream with key 0x01, back-to-back
    drive(1, 8'h01, 0, 0, 0, 1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, c3[i], 0, 1); tick();
      chk("t3_lat", out_valid, 1); chk("t3_data", out_data, p3[i]);
    end
    drive(0, 0, 0, 0, 0, 1); tick();
    chk("t3_cnt", byte_count, 5);

    // Async reset mid-cycle with a byte pending
    drive(1, 8'h01, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 8'h41, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1;
    #1;
    chk("mrst_out_valid", out_valid, 0); chk("mrst_in_ready", in_ready, 0);
    chk("mrst_keyed", keyed, 0); chk("mrst_cnt", byte_count, 0);
    model_reset();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Frame resync
    drive(1, 8'h01, 0, 0, 0, 1); tick();
    drive(0, 0, 1, 8'h41, 0, 1); tick(); chk("t4_d0", out_data, 8'h40); chk("t4_l0", out_last, 0);
    drive(0, 0, 1, 8'h42, 1, 1); tick(); chk("t4_d1", out_data, 8'h40); chk("t4_l1", out_last, 1);
    drive(0, 0, 1, 8'h41, 0, 1); tick(); chk("t4_d2", out_data, 8'h40); chk("t4_l2", out_last, 0);
    drive(0, 0, 1, 8'h42, 0, 1); tick(); chk("t4_d3", out_data, 8'h40); chk("t4_l3", out_last, 0);
    drive(0, 0, 0, 0, 0, 1); tick();

    // Backpressure
    drive(1, 8'h01, 0, 0, 0, 1); tick();
    drive(0, 0, 1, 8'h41, 0, 1); tick();
    drive(0, 0, 1, 8'h42, 0, 1); tick();
    drive(0, 0, 1, 8'h44, 0, 0);
    repeat (3) begin tick(); chk("t5_hold", out_data, 8'h40); end
    drive(0, 0, 1, 8'h44, 0, 1); tick(); chk("t5_d2", out_data, 8'h40);
    drive(0, 0, 1, 8'h48, 0, 1); tick(); chk("t5_d3", out_data, 8'h40);
    drive(0, 0, 1, 8'h11, 0, 1); tick(); chk("t5_d4", out_data, 8'h00);
    drive(0, 0, 0, 0, 0, 1); tick();
    chk("t5_cnt", byte_count, 5);
    // Zero key falls back to the default seed
    drive(1, 8'h00, 0, 0, 0, 1); tick();
    drive(0, 0, 1, 8'hA5, 0, 1); tick(); chk("t5_zkey", out_data, 8'h00);
    drive(0, 0, 0, 0, 0, 1); tick();

    // Rekey with a pending byte and a valid input in the same cycle
    drive(1, 8'h01, 0, 0, 0, 1); tick();
    drive(0, 0, 1, 8'h41, 0, 0); tick();
    drive(1, 8'h03, 1, 8'h77, 0, 0); tick();
    chk("t6_drop", out_valid, 0); chk("t6_cnt", byte_count, 0);
    drive(0, 0, 1, 8'h13, 0, 1); tick(); chk("t6_newkey", out_data, 8'h10);
    drive(0, 0, 0, 0, 0, 1); tick();

    // Random round trip: plaintext encrypted by the model, decrypted by the DUT
    drive(1, 8'($urandom), 0, 0, 0, 1); tick();
    acc = 0; cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      p = 8'($urandom);
      key_load  = ($urandom_range(0, 99) == 0);
      key_in    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      in_valid  = ($urandom_range(0, 4) != 0);
      in_last   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = p ^ ks(mkey, midx);
      acc_now   = in_valid && mkeyed && !key_load && (!mov || out_ready);
      tick();
      if (acc_now) begin
        acc++;
        chk("roundtrip", out_data, p);
      end
      cyc++;
    end
    chk("rt_bytes_done", (acc >= 1000) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
